// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO peripheral: register map,
// STATUS layout, empty-read sentinel and receiver state encodings.
package uart_rx_fifo_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [3:0] ADDR_THRESH = 4'hC;

    localparam int ST_AVAIL      = 0;
    localparam int ST_OVF        = 1;
    localparam int ST_CNT_LSB    = 2;
    localparam int ST_OVFCNT_LSB = 8;

    localparam logic [31:0] EMPTY_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic logic [31:0] status_word(input logic [7:0] ovf_cnt,
                                                input logic [5:0] cnt,
                                                input logic       ovf,
                                                input logic       avail);
        logic [31:0] w;
        w                      = '0;
        w[ST_AVAIL]            = avail;
        w[ST_OVF]              = ovf;
        w[ST_CNT_LSB +: 6]     = cnt;
        w[ST_OVFCNT_LSB +: 8]  = ovf_cnt;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// CPU memory-mapped valid/ready bus as seen by the UART receive block.
interface uart_rx_fifo_if;
    logic        valid;
    logic [3:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output valid, addr, wstrb, wdata, input rdata, ready);
    modport slave  (input valid, addr, wstrb, wdata, output rdata, ready);
endinterface

// File: rtl/uart_rx_fifo_core.sv
// Serial receiver: synchroniser, bit-period down-counter, framing FSM and
// shift register. Emits one-cycle byte_valid / frame_err pulses.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a low level
// RX_START | counting to mid start bit; high there means glitch
// RX_DATA  | sampling 8 data bits LSB first, one per bit period
// RX_STOP  | sampling stop bit; on framing error wait for line high
module uart_rx_core
    import uart_rx_fifo_pkg::*;
#(
    parameter int DIV = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic          err_q, err_d;
    logic          bv_d, fe_d;

    assign rx_s    = sync_q[1];
    assign rx_byte = shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            bit_q      <= '0;
            err_q      <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx_in};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            err_q      <= err_d;
            byte_valid <= bv_d;
            frame_err  <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        err_d   = err_q;
        bv_d    = 1'b0;
        fe_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                err_d = 1'b0;
                if (!rx_s) begin
                    state_d = RX_START;
                    cnt_d   = CW'(HALF - 1);
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        state_d = RX_DATA;
                        cnt_d   = CW'(DIV - 1);
                        bit_d   = 3'd0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = CW'(DIV - 1);
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                // After a bad stop bit, hold here so a long break is not
                // mistaken for a new start bit.
                if (err_q) begin
                    if (rx_s) state_d = RX_IDLE;
                end else if (cnt_q == '0) begin
                    if (rx_s) begin
                        bv_d    = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        fe_d  = 1'b1;
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive peripheral: receiver core, byte FIFO and register file on the
// cpu_mem bus. UART_RX_FIFO_IRQ_EN enables the threshold interrupt.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int SYSTEM_CLK = 25_000_000,
    parameter int BAUDRATE   = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_in,
    uart_rx_fifo_if.slave  bus,
    output logic           irq
);

    localparam int DIV   = SYSTEM_CLK / BAUDRATE;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic          byte_valid, frame_err;
    logic [7:0]    rx_byte;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr, rptr, count;
    logic [5:0]    count6;
    logic          full, empty;
    logic          acc, is_wr, pop, push, drop, flush, clr;
    logic          ovf_q;
    logic [7:0]    ovf_cnt;
    logic [31:0]   rd_word;
    logic          rx_ok;

    uart_rx_core #(.DIV(DIV)) u_core (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    assign count  = wptr - rptr;
    assign count6 = 6'(count);
    assign full   = (count == PW'(DEPTH));
    assign empty  = (count == '0);

    assign acc   = bus.valid && !bus.ready;
    assign is_wr = |bus.wstrb;
    assign pop   = acc && !is_wr && (bus.addr == ADDR_DATA) && !empty;
    assign flush = acc && is_wr && (bus.addr == ADDR_CTRL) && bus.wdata[0];
    assign clr   = acc && is_wr && (bus.addr == ADDR_CTRL) && bus.wdata[1];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign rx_ok = byte_valid && !frame_err;
    assign push  = rx_ok && (!full || pop);
    assign drop  = rx_ok && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wptr[DEPTH_LOG2-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (flush)    rptr <= wptr;
            else if (pop) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ovf_q   <= 1'b0;
            ovf_cnt <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

`ifdef UART_RX_FIFO_IRQ_EN
    logic [5:0] thresh;

    always_ff @(posedge clk) begin
        if (rst) begin
            thresh <= 6'd1;
            irq    <= 1'b0;
        end else begin
            if (acc && is_wr && (bus.addr == ADDR_THRESH)) thresh <= bus.wdata[5:0];
            irq <= (count6 >= thresh) && (thresh != 6'd0);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_word = '0;
        if (!is_wr) begin
            case (bus.addr)
                ADDR_DATA:   rd_word = empty ? EMPTY_WORD
                                             : {24'b0, mem[rptr[DEPTH_LOG2-1:0]]};
                ADDR_STATUS: rd_word = status_word(ovf_cnt, count6, ovf_q, !empty);
`ifdef UART_RX_FIFO_IRQ_EN
                ADDR_THRESH: rd_word = {26'b0, thresh};
`endif
                default:     rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ready <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ready <= acc;
            bus.rdata <= acc ? rd_word : 32'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: bus accesses queue expected read data,
// a negedge monitor checks each ready pulse. Honours UART_RX_FIFO_IRQ_EN.
module tb_uart_rx_fifo;

    localparam int  CLK_HALF = 20;
    localparam int  DIV      = 16;
    localparam time BIT      = DIV * 2 * CLK_HALF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_in = 1'b1;
    logic irq;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(
        .SYSTEM_CLK (25_000_000),
        .BAUDRATE   (1_562_500),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_in (rx_in),
        .bus   (bus.slave),
        .irq   (irq)
    );

    always #CLK_HALF clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got rdata %08h want no response", bus.rdata);
            end else begin
                check("rdata", bus.rdata, exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] st(input int ovfc, input int cnt, input bit ovf, input bit avail);
        return {16'b0, 8'(ovfc), 6'(cnt), ovf, avail};
    endfunction

    task automatic bus_acc(input logic [3:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic [31:0] e);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.addr  = a;
        bus.wstrb = s;
        bus.wdata = d;
        exp_q.push_back(e);
        @(negedge clk);
        bus.valid = 1'b0;
        bus.wstrb = 4'h0;
        @(negedge clk);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        bus_acc(a, 4'h0, 32'h0, e);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus_acc(a, 4'hF, d, 32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_in = 1'b0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            #BIT;
        end
        rx_in = 1'b1;
        #BIT;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid = 1'b0;
        bus.addr  = 4'h0;
        bus.wstrb = 4'h0;
        bus.wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, bus.ready}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rd(4'h4, 32'h0);

        // two bytes, register map basics
        send_byte(8'h55);
        send_byte(8'hA3);
        rd(4'h4, st(0, 2, 0, 1));
        wr(4'h4, 32'hFFFF_FFFF);
        wr(4'h0, 32'h0000_0012);
        rd(4'h4, st(0, 2, 0, 1));
        rd(4'h0, 32'h0000_0055);
        rd(4'h0, 32'h0000_00A3);
        rd(4'h0, 32'hFFFF_FFFF);
        rd(4'h8, 32'h0);
        wr(4'h6, 32'h3);
        rd(4'h4, 32'h0);

        // overflow: 18 bytes into a 16-deep FIFO
        for (int i = 0; i < 18; i++) send_byte(8'(i));
        rd(4'h4, st(2, 16, 1, 1));
        for (int i = 0; i < 16; i++) rd(4'h0, 32'(i));
        rd(4'h0, 32'hFFFF_FFFF);
        wr(4'h8, 32'h2);
        rd(4'h4, 32'h0);

        // full FIFO, pop coinciding with a completing byte
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
        rd(4'h4, st(0, 16, 0, 1));
        fork
            send_byte(8'h30);
            begin
                int n = 0;
                while (!dut.byte_valid && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 400) begin
                    total++;
                    bad++;
                    $display("FAIL byte_valid_wait: got timeout want pulse");
                end else begin
                    bus.valid = 1'b1;
                    bus.addr  = 4'h0;
                    bus.wstrb = 4'h0;
                    exp_q.push_back(32'h0000_0020);
                    @(negedge clk);
                    bus.valid = 1'b0;
                end
            end
        join
        rd(4'h4, st(0, 16, 0, 1));
        rd(4'h0, 32'h0000_0021);
        wr(4'h8, 32'h1);
        rd(4'h4, 32'h0);

        // glitch, then bad stop bit, then good byte
        rx_in = 1'b0;
        #200ns;
        rx_in = 1'b1;
        #(3 * BIT);
        rd(4'h4, 32'h0);
        rx_in = 1'b0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            rx_in = i[0];
            #BIT;
        end
        rx_in = 1'b0;
        #(3 * BIT);
        rx_in = 1'b1;
        #(2 * BIT);
        rd(4'h4, 32'h0);
        send_byte(8'h7E);
        rd(4'h4, st(0, 1, 0, 1));
        rd(4'h0, 32'h0000_007E);

        // threshold interrupt and flush
        wr(4'hC, 32'h3);
`ifdef UART_RX_FIFO_IRQ_EN
        rd(4'hC, 32'h3);
`else
        rd(4'hC, 32'h0);
`endif
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (2) @(negedge clk);
        check("irq_below", {31'b0, irq}, 32'h0);
        send_byte(8'h33);
        repeat (2) @(negedge clk);
`ifdef UART_RX_FIFO_IRQ_EN
        check("irq_at_thresh", {31'b0, irq}, 32'h1);
`else
        check("irq_at_thresh", {31'b0, irq}, 32'h0);
`endif
        rd(4'h4, st(0, 3, 0, 1));
        rd(4'h0, 32'h0000_0011);
        repeat (2) @(negedge clk);
        check("irq_after_pop", {31'b0, irq}, 32'h0);
        wr(4'h8, 32'h1);
        rd(4'h4, 32'h0);

        // reset mid-frame and mid-transaction
        send_byte(8'h44);
        rx_in = 1'b0;
        #(3 * BIT);
        @(negedge clk);
        rst       = 1'b1;
        bus.valid = 1'b1;
        bus.addr  = 4'h4;
        bus.wstrb = 4'h0;
        @(negedge clk);
        check("rst_mid_ready", {31'b0, bus.ready}, 32'h0);
        bus.valid = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        rx_in = 1'b1;
        #(12 * BIT);
        rd(4'h4, 32'h0);
        send_byte(8'h3C);
        rd(4'h4, st(0, 1, 0, 1));
        rd(4'h0, 32'h0000_003C);

        repeat (4) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
